// File: rtl/regfile_scoreboard_pkg.sv
// Shared processor constants: register-file geometry, register-address type, helpers.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package regfile_scoreboard_pkg;

    // Default register-file geometry; instances may override WIDTH/DEPTH,
    // but the address width is always derived from DEPTH.
    localparam int RF_WIDTH = 32;
    localparam int RF_DEPTH = 32;
    localparam int RF_AW    = $clog2(RF_DEPTH);

    // Architectural register address for the default geometry.
    typedef logic [RF_AW-1:0] reg_addr_t;

    // Widest busy vector the population count has to handle (DEPTH <= 64).
    localparam int POP_MAX_BITS = 64;

    // Population count of up to 64 busy bits; result fits in 7 bits.
    function automatic logic [6:0] popcount64(input logic [POP_MAX_BITS-1:0] v);
        logic [6:0] n;
        n = '0;
        for (int i = 0; i < POP_MAX_BITS; i++) begin
            n = n + 7'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/regfile_scoreboard_busy_table.sv
// Busy-bit table: one pending-write flag per register, registered population count, bypass-aware lookup.
// Latency: busy bits and busy_count update one edge after issue/write; busy_a/busy_b lookups are combinational.
// Backpressure: none; every issue and write is absorbed in the cycle it is presented.
module regfile_busy_table
    import regfile_scoreboard_pkg::*;
#(
    parameter  int DEPTH = RF_DEPTH,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          issue_valid,
    input  logic [AW-1:0] issue_dest,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [AW-1:0] raddr_a,
    input  logic [AW-1:0] raddr_b,
    output logic          busy_a,
    output logic          busy_b,
    output logic [AW:0]   busy_count
);

    logic [DEPTH-1:0] busy;
    logic [DEPTH-1:0] busy_nxt;
    logic [AW:0]      count_nxt;
    logic             wr_clear;
    logic             iss_set;

    // Writes to r0 are discarded and r0 is never tracked as busy.
    assign wr_clear = we && (waddr != '0);
    assign iss_set  = issue_valid && (issue_dest != '0);

    // Next busy vector: clear on write first, then set on issue so a
    // same-cycle issue to the written register keeps it outstanding.
    always_comb begin
        busy_nxt = busy;
        if (wr_clear) begin
            busy_nxt[waddr] = 1'b0;
        end
        if (iss_set) begin
            busy_nxt[issue_dest] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    // Count is taken from the next vector so simultaneous set and clear stay exact;
    // r0 is never busy, so the count tops out at DEPTH-1 and cannot wrap.
    always_comb begin
        count_nxt = (AW+1)'(popcount64(POP_MAX_BITS'(busy_nxt)));
    end

    // Busy state and its registered population count; reset wins over issue/write.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy       <= '0;
            busy_count <= '0;
        end else begin
            busy       <= busy_nxt;
            busy_count <= count_nxt;
        end
    end

    // Lookup hides busy for a register being written this cycle, since its
    // value is already available through the data bypass.
    always_comb begin
        busy_a = busy[raddr_a] && !(we && (waddr == raddr_a));
        busy_b = busy[raddr_b] && !(we && (waddr == raddr_b));
    end

endmodule

// File: rtl/regfile_scoreboard.sv
// Two-read one-write register file with write bypass and a pending-write scoreboard.
// Latency: reads and busy lookups combinational (same-cycle write bypassed); writes land at the next edge.
// Backpressure: none; reads, writes and issues are accepted every cycle.
module regfile_scoreboard
    import regfile_scoreboard_pkg::*;
#(
    parameter  int WIDTH = RF_WIDTH,
    parameter  int DEPTH = RF_DEPTH,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [AW-1:0]    raddr_a,
    input  logic [AW-1:0]    raddr_b,
    output logic [WIDTH-1:0] rdata_a,
    output logic [WIDTH-1:0] rdata_b,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             issue_valid,
    input  logic [AW-1:0]    issue_dest,
    output logic             busy_a,
    output logic             busy_b,
    output logic [AW:0]      busy_count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic             wr_live;

    // A write to r0 never changes architectural state.
    assign wr_live = we && (waddr != '0);

    // Data array: cleared by reset, otherwise written on a live write.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_live) begin
            mem[waddr] <= wdata;
        end
    end

    // Read ports: r0 reads zero, a same-cycle write to the read address is
    // forwarded, otherwise the stored value. Both ports are independent.
    always_comb begin
        rdata_a = mem[raddr_a];
        rdata_b = mem[raddr_b];
        if (wr_live && (waddr == raddr_a)) begin
            rdata_a = wdata;
        end
        if (wr_live && (waddr == raddr_b)) begin
            rdata_b = wdata;
        end
        if (raddr_a == '0) begin
            rdata_a = '0;
        end
        if (raddr_b == '0) begin
            rdata_b = '0;
        end
    end

    regfile_busy_table #(
        .DEPTH (DEPTH)
    ) u_busy_table (
        .clk         (clk),
        .reset       (reset),
        .issue_valid (issue_valid),
        .issue_dest  (issue_dest),
        .we          (we),
        .waddr       (waddr),
        .raddr_a     (raddr_a),
        .raddr_b     (raddr_b),
        .busy_a      (busy_a),
        .busy_b      (busy_b),
        .busy_count  (busy_count)
    );

endmodule
